// File: rtl/matvec_pkg.sv
// Shared types and width helpers for the parametrised matrix-vector controller.
package matvec_pkg;

    typedef enum logic [2:0] {
        RST,
        WAIT_NEW,
        LOAD_W,
        LOAD_X,
        MULT,
        DRAIN,
        SEND
    } state_t;

    // Counter/select width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned aw_of(input int unsigned rows, input int unsigned cols,
                                          input int unsigned lanes);
        return clog2_min1((rows * cols) / lanes);
    endfunction

    function automatic int unsigned xw_of(input int unsigned cols);
        return clog2_min1(cols);
    endfunction

    function automatic int unsigned lw_of(input int unsigned lanes);
        return clog2_min1(lanes);
    endfunction

endpackage

// File: rtl/mv_delay_line.sv
// Fixed-depth 1-bit shift register with synchronous reset.
module mv_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = (sr_q << 1) | DEPTH'(din);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/matvec_ctrl_param.sv
// Controller for the y = W*x engine: buffer loads, LANES-wide row-group MAC
// sequencing, and per-lane result handoff over valid/ready.
module matvec_ctrl_param
    import matvec_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned LANES   = 1,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  input_valid,
    output logic                                  input_ready,
    input  logic                                  new_matrix,
    output logic [aw_of(ROWS, COLS, LANES)-1:0]   addr_w,
    output logic [LANES-1:0]                      wr_en_w,
    output logic [xw_of(COLS)-1:0]                addr_x,
    output logic                                  wr_en_x,
    output logic                                  en_acc,
    output logic                                  clear_acc,
    output logic                                  output_valid,
    input  logic                                  output_ready,
    output logic [lw_of(LANES)-1:0]               out_lane
);

    localparam int unsigned AW     = aw_of(ROWS, COLS, LANES);
    localparam int unsigned XW     = xw_of(COLS);
    localparam int unsigned LW     = lw_of(LANES);
    localparam int unsigned GROUPS = ROWS / LANES;
    localparam int unsigned GW     = clog2_min1(GROUPS);
    localparam int unsigned EW     = AW + ((LANES > 1) ? $clog2(LANES) : 0);
    localparam int unsigned DW     = clog2_min1(MAC_LAT);
    localparam int unsigned ELEMS  = ROWS * COLS;

    state_t          state_q, state_d;
    logic [EW-1:0]   elem_q,  elem_d;
    logic [XW-1:0]   col_q,   col_d;
    logic [LW-1:0]   lane_q,  lane_d;
    logic [GW-1:0]   group_q, group_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic            accepting;
    logic            beat;
    logic            mult_flag;
    logic            col_last, lane_last, group_last, elem_last, drain_last;
    logic [XW-1:0]   col_nxt;
    logic [LW-1:0]   lane_nxt;
    logic [GW-1:0]   group_nxt;
    logic [EW-1:0]   elem_nxt;
    logic [DW-1:0]   drain_nxt;
    logic [LANES-1:0] w_sel;

    assign accepting = (state_q == WAIT_NEW) || (state_q == LOAD_W) || (state_q == LOAD_X);
    assign beat      = input_valid && accepting;

    assign col_last   = (col_q   == XW'(COLS - 1));
    assign lane_last  = (lane_q  == LW'(LANES - 1));
    assign group_last = (group_q == GW'(GROUPS - 1));
    assign elem_last  = (elem_q  == EW'(ELEMS - 1));
    assign drain_last = (drain_q == DW'(MAC_LAT - 1));

    // Wrapping increments; every counter returns to 0 at its terminal count.
    assign col_nxt   = col_last   ? '0 : col_q   + XW'(1);
    assign lane_nxt  = lane_last  ? '0 : lane_q  + LW'(1);
    assign group_nxt = group_last ? '0 : group_q + GW'(1);
    assign elem_nxt  = elem_last  ? '0 : elem_q  + EW'(1);
    assign drain_nxt = drain_last ? '0 : drain_q + DW'(1);

    // Row r of W maps to lane r%LANES (lane_q) and bank row r/LANES (group_q).
    assign w_sel = LANES'(1) << lane_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST;
            elem_q  <= '0;
            col_q   <= '0;
            lane_q  <= '0;
            group_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            col_q   <= col_d;
            lane_q  <= lane_d;
            group_q <= group_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        col_d        = col_q;
        lane_d       = lane_q;
        group_d      = group_q;
        drain_d      = drain_q;
        input_ready  = accepting;
        wr_en_w      = '0;
        wr_en_x      = 1'b0;
        clear_acc    = 1'b0;
        output_valid = 1'b0;
        out_lane     = '0;
        mult_flag    = 1'b0;
        addr_x       = col_q;
        addr_w       = AW'(group_q) * AW'(COLS) + AW'(col_q);

        case (state_q)
            RST: begin
                clear_acc = 1'b1;
                state_d   = LOAD_W;
            end
            WAIT_NEW: begin
                if (beat) begin
                    col_d = col_nxt;
                    if (new_matrix) begin
                        wr_en_w = w_sel;
                        elem_d  = elem_nxt;
                        state_d = LOAD_W;
                    end else begin
                        wr_en_x = 1'b1;
                        state_d = LOAD_X;
                    end
                end
            end
            LOAD_W: begin
                if (beat) begin
                    wr_en_w = w_sel;
                    col_d   = col_nxt;
                    elem_d  = elem_nxt;
                    if (col_last) begin
                        lane_d = lane_nxt;
                        if (lane_last) begin
                            group_d = group_nxt;
                        end
                    end
                    if (elem_last) begin
                        state_d = LOAD_X;
                    end
                end
            end
            LOAD_X: begin
                if (beat) begin
                    wr_en_x = 1'b1;
                    col_d   = col_nxt;
                    if (col_last) begin
                        state_d = MULT;
                    end
                end
            end
            MULT: begin
                mult_flag = 1'b1;
                col_d     = col_nxt;
                if (col_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_nxt;
                if (drain_last) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                output_valid = 1'b1;
                out_lane     = lane_q;
                if (output_ready) begin
                    lane_d = lane_nxt;
                    if (lane_last) begin
                        clear_acc = 1'b1;
                        group_d   = group_nxt;
                        state_d   = group_last ? WAIT_NEW : MULT;
                    end
                end
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    // Accumulate enable trails the read addresses by the multiplier latency.
    mv_delay_line #(
        .DEPTH (MAC_LAT)
    ) u_acc_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (mult_flag),
        .dout (en_acc)
    );

endmodule

// File: tb/tb_matvec_ctrl_param.sv
// Self-checking bench: two controller configurations checked against a
// timeline model of load beats, MAC windows and result handoffs.
module tb_matvec_ctrl_param;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int P_RST  = 0;
    localparam int P_LOAD = 1;
    localparam int P_COMP = 2;

    logic clk;
    logic rst, input_valid, new_matrix, output_ready;

    logic       ir_a, wrx_a, en_a, clr_a, ov_a;
    logic [5:0] aw_a;
    logic [0:0] wrw_a;
    logic [2:0] ax_a;
    logic [0:0] ol_a;

    logic       ir_b, wrx_b, en_b, clr_b, ov_b;
    logic [4:0] aw_b;
    logic [1:0] wrw_b;
    logic [2:0] ax_b;
    logic [0:0] ol_b;

    int n_checks;
    int n_fail;

    typedef struct {
        int ir; int clr; int wrw; int wrx; int ov; int en; int lane; int aw; int ax;
    } obs_t;

    typedef struct {
        bit   rst; bit iv; bit nm; bit ordy;
        obs_t exp;
    } vec_t;

    matvec_ctrl_param #(.ROWS(ROWS), .COLS(COLS), .LANES(1), .MAC_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .input_valid(input_valid), .input_ready(ir_a),
        .new_matrix(new_matrix), .addr_w(aw_a), .wr_en_w(wrw_a), .addr_x(ax_a),
        .wr_en_x(wrx_a), .en_acc(en_a), .clear_acc(clr_a), .output_valid(ov_a),
        .output_ready(output_ready), .out_lane(ol_a)
    );

    matvec_ctrl_param #(.ROWS(ROWS), .COLS(COLS), .LANES(2), .MAC_LAT(4)) u_dut_b (
        .clk(clk), .rst(rst), .input_valid(input_valid), .input_ready(ir_b),
        .new_matrix(new_matrix), .addr_w(aw_b), .wr_en_w(wrw_b), .addr_x(ax_b),
        .wr_en_x(wrx_b), .en_acc(en_b), .clear_acc(clr_b), .output_valid(ov_b),
        .output_ready(output_ready), .out_lane(ol_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe(input int k);
        obs_t o;
        if (k == 0) begin
            o = '{int'(ir_a), int'(clr_a), int'(wrw_a), int'(wrx_a), int'(ov_a), int'(en_a),
                  int'(ol_a), int'(aw_a), int'(ax_a)};
        end else begin
            o = '{int'(ir_b), int'(clr_b), int'(wrw_b), int'(wrx_b), int'(ov_b), int'(en_b),
                  int'(ol_b), int'(aw_b), int'(ax_b)};
        end
        return o;
    endfunction

    function automatic void chk(input int k, input string what, input int cyc,
                                input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s at cycle %0d: got %0d, expected %0d", k, what, cyc, act, exp);
        end
    endfunction

    // Fields with an expected value of -1 are don't-care this cycle.
    function automatic void compare(input int k, input int cyc, input obs_t a, input obs_t e);
        chk(k, "input_ready",  cyc, a.ir,  e.ir);
        chk(k, "clear_acc",    cyc, a.clr, e.clr);
        chk(k, "wr_en_w",      cyc, a.wrw, e.wrw);
        chk(k, "wr_en_x",      cyc, a.wrx, e.wrx);
        chk(k, "output_valid", cyc, a.ov,  e.ov);
        chk(k, "en_acc",       cyc, a.en,  e.en);
        if (e.lane >= 0) chk(k, "out_lane", cyc, a.lane, e.lane);
        if (e.aw >= 0)   chk(k, "addr_w",   cyc, a.aw,   e.aw);
        if (e.ax >= 0)   chk(k, "addr_x",   cyc, a.ax,   e.ax);
    endfunction

    function automatic vec_t mk(input bit r, input bit iv, input bit nm, input bit ordy,
                                input int ir, input int clr, input int wrw, input int aw);
        vec_t v;
        v.rst = r; v.iv = iv; v.nm = nm; v.ordy = ordy;
        v.exp = '{ir, clr, wrw, 0, 0, 0, -1, aw, -1};
        return v;
    endfunction

    task automatic run(input int k);
        vec_t tbl[6];
        obs_t e;
        int   lanes, lat, groups, rc;
        int   ph, first, wl, xl, t_start, grp, sent, cyc, last_rst, op, stall;
        int   rel, eff_wl, eff_xl, kk, row;
        bit   mult_now;
        bit   hist[int];

        lanes  = (k == 0) ? 1 : 2;
        lat    = (k == 0) ? 1 : 4;
        groups = ROWS / lanes;
        rc     = ROWS * COLS;

        // Reset entry, ignored beats in RST, first W writes, mid-load reset.
        tbl[0] = mk(1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 0, 0);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0);
        tbl[2] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, -1);
        tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1, 0);
        tbl[4] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 1, 1);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 0, 0);

        rst = 1'b1; input_valid = 1'b0; new_matrix = 1'b0; output_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            rst = tbl[i].rst; input_valid = tbl[i].iv;
            new_matrix = tbl[i].nm; output_ready = tbl[i].ordy;
            @(negedge clk);
            compare(k, i - 6, observe(k), tbl[i].exp);
            @(posedge clk);
            #1;
        end

        ph = P_LOAD; first = 0; wl = rc; xl = COLS;
        t_start = 0; grp = 0; sent = 0; cyc = 0; last_rst = -1000; op = 0; stall = 0;

        while (op < 5 && cyc < 8000) begin
            rel = cyc - t_start;
            rst = (ph == P_COMP && op == 2 && grp == 2 && rel == 3);
            if (ph == P_COMP && op == 1 && grp == 0 && sent == 0 && rel == COLS + lat) stall = 5;
            input_valid = ($urandom_range(0, 3) != 0);
            if (first != 0 && op == 1)      new_matrix = 1'b0;
            else if (first != 0 && op == 2) new_matrix = 1'b1;
            else                            new_matrix = ($urandom_range(0, 1) == 1);
            if (stall > 0) begin
                output_ready = 1'b0;
                stall--;
            end else begin
                output_ready = ($urandom_range(0, 2) != 0);
            end

            eff_wl = (first != 0) ? (new_matrix ? rc : 0) : wl;
            eff_xl = (first != 0) ? COLS : xl;
            e = '{0, 0, 0, 0, 0, 0, -1, -1, -1};
            mult_now = 1'b0;
            case (ph)
                P_RST: begin
                    e.clr = 1; e.lane = 0; e.aw = 0; e.ax = 0;
                end
                P_LOAD: begin
                    e.ir = 1;
                    if (input_valid) begin
                        if (eff_wl > 0) begin
                            kk    = rc - eff_wl;
                            row   = kk / COLS;
                            e.wrw = 1 << (row % lanes);
                            e.aw  = (row / lanes) * COLS + kk % COLS;
                        end else begin
                            e.wrx = 1;
                            e.ax  = COLS - eff_xl;
                        end
                    end
                end
                default: begin
                    if (rel < COLS) begin
                        mult_now = 1'b1;
                        e.aw = grp * COLS + rel;
                        e.ax = rel;
                    end else if (rel >= COLS + lat) begin
                        e.ov   = 1;
                        e.lane = sent;
                        e.clr  = (output_ready && sent == lanes - 1) ? 1 : 0;
                    end
                end
            endcase
            e.en = (cyc - lat > last_rst && hist.exists(cyc - lat)) ? 1 : 0;
            if (mult_now) hist[cyc] = 1'b1;

            @(negedge clk);
            compare(k, cyc, observe(k), e);
            @(posedge clk);

            if (rst) begin
                ph = P_RST; last_rst = cyc; op++;
            end else begin
                case (ph)
                    P_RST: begin
                        ph = P_LOAD; first = 0; wl = rc; xl = COLS;
                    end
                    P_LOAD: begin
                        if (input_valid) begin
                            wl = eff_wl; xl = eff_xl; first = 0;
                            if (wl > 0) wl--; else xl--;
                            if (wl == 0 && xl == 0) begin
                                ph = P_COMP; t_start = cyc + 1; grp = 0; sent = 0;
                            end
                        end
                    end
                    default: begin
                        if (e.ov == 1 && output_ready) begin
                            sent++;
                            if (sent == lanes) begin
                                sent = 0;
                                grp++;
                                if (grp == groups) begin
                                    ph = P_LOAD; first = 1; op++;
                                end else begin
                                    t_start = cyc + 1;
                                end
                            end
                        end
                    end
                endcase
            end
            #1;
            cyc++;
        end
        chk(k, "operations_completed", cyc, op, 5);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        run(0);
        run(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
